// File: rtl/smol_boi_if.sv
// SPI pin bundle between an external master and the smol_boi register-file slave.
`timescale 1ns/1ps
interface smol_boi_if;
    logic CS;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output CS, output SCLK, output MOSI, input MISO);
    modport slave  (input CS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/smol_boi.sv
// SPI mode-0 slave in front of a flop-based register file; pins are oversampled on CLK.
// Optional SMOL_BOI_FRAME_CNT_EN turns the top address into a read-only completed-frame counter.
`timescale 1ns/1ps
module smol_boi #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic      CLK,
    input  logic      RST,
    smol_boi_if.slave spi
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int BC_W = (DATA_W > 8) ? $clog2(DATA_W) : 3;
    localparam logic [BC_W-1:0] HDR_LAST  = BC_W'(7);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);
`ifdef SMOL_BOI_FRAME_CNT_EN
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
`endif

    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sclk_prev_q;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_rise, cs_fall, sclk_rise, sclk_fall;

    state_t              state_q, state_d;
    logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
    logic [6:0]          hdr_q, hdr_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic                miso_q, miso_d;
    logic                wr_en;
    logic [7:0]          hdr_shift;
    logic [DATA_W-1:0]   rx_shift;
    logic [DATA_W-1:0]   regs_q [NREG];

    // Synchronizers reset to 0 so a CS held low through reset never looks like a fresh fall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.CS};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    assign hdr_shift = {hdr_q, mosi_s};
    assign rx_shift  = DATA_W'({rx_q, mosi_s});

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            hdr_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            hdr_q    <= hdr_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            miso_q   <= miso_d;
        end
    end

    // A CS edge outranks any SCLK edge seen in the same cycle.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        hdr_d    = hdr_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        miso_d   = miso_q;
        wr_en    = 1'b0;
        if (cs_rise) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            miso_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    miso_d   = 1'b0;
                    bitcnt_d = '0;
                    if (cs_fall) state_d = HDR;
                end
                HDR: begin
                    if (sclk_rise) begin
                        hdr_d    = hdr_shift[6:0];
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == HDR_LAST) begin
                            addr_d   = ADDR_W'(hdr_shift);
                            rw_d     = hdr_shift[7];
                            tx_d     = regs_q[ADDR_W'(hdr_shift)];
                            bitcnt_d = '0;
                            state_d  = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        rx_d     = rx_shift;
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == DATA_LAST) begin
                            bitcnt_d = '0;
                            state_d  = DONE;
                            wr_en    = ~rw_q;
                        end
                    end else if (sclk_fall) begin
                        if (rw_q) begin
                            miso_d = tx_q[DATA_W-1];
                            tx_d   = tx_q << 1;
                        end else begin
                            miso_d = 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (sclk_fall) miso_d = 1'b0;
                end
            endcase
        end
    end

    // The last data bit is held until the next fall so MISO only moves on falls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
`ifdef SMOL_BOI_FRAME_CNT_EN
            if (wr_en && (addr_q != TOP_ADDR)) regs_q[addr_q] <= rx_shift;
            if ((state_q == DATA) && (state_d == DONE))
                regs_q[TOP_ADDR] <= regs_q[TOP_ADDR] + DATA_W'(1);
`else
            if (wr_en) regs_q[addr_q] <= rx_shift;
`endif
        end
    end

    assign spi.MISO = miso_q;

endmodule

// File: tb/tb_smol_boi.sv
// Self-checking bench for smol_boi: directed table, reset/abort sequences and random frames vs a frame-level model.
`timescale 1ns/1ps
module tb_smol_boi;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    smol_boi_if spi ();

    smol_boi #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .spi(spi)
    );

    always #10 CLK = ~CLK;

`ifdef SMOL_BOI_FRAME_CNT_EN
    localparam bit CNT_MODE = 1'b1;
`else
    localparam bit CNT_MODE = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [16];
    int frames;

    typedef struct {
        string       name;
        int          n;
        logic [63:0] tx;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        frames = 0;
    endtask

    // Frame-level behaviour: snapshot at header end, commit and count only on full frames.
    task automatic model_frame(input int n, input logic [63:0] tx, output logic [63:0] rsp);
        logic [7:0] hdr, snap, data;
        logic [3:0] a;
        rsp = '0;
        if (n >= 8) begin
            hdr  = tx[n-1 -: 8];
            a    = hdr[3:0];
            snap = (CNT_MODE && a == 4'hF) ? 8'(frames) : mem[a];
            if (hdr[7])
                for (int j = 0; j < 8; j++)
                    if (8 + j < n) rsp[n-9-j] = snap[7-j];
            if (n >= 16) begin
                data = tx[n-9 -: 8];
                if (!hdr[7] && !(CNT_MODE && a == 4'hF)) mem[a] = data;
                frames++;
            end
        end
    endtask

    task automatic shift_bits(input int n, input logic [63:0] tx, output logic [63:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            spi.MOSI = tx[n-1-i];
            #200;
            rx[n-1-i] = spi.MISO;
            spi.SCLK = 1'b1;
            #200;
            spi.SCLK = 1'b0;
        end
        #200;
    endtask

    task automatic xfer(input int n, input logic [63:0] tx, output logic [63:0] rx);
        spi.CS = 1'b0;
        #200;
        shift_bits(n, tx, rx);
        spi.CS = 1'b1;
        #400;
    endtask

    task automatic run_frame(input string name, input int n, input logic [63:0] tx);
        logic [63:0] rx, mrsp;
        model_frame(n, tx, mrsp);
        xfer(n, tx, rx);
        check(name, rx, mrsp);
    endtask

    task automatic pulse_reset();
        @(negedge CLK) RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        #1500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rx, mrsp;
        logic [15:0] w;
        int n, kind;

        tbl[0] = '{"wr3_55",     16, 64'h0355,  64'h0000};
        tbl[1] = '{"rd3_55",     16, 64'h8300,  64'h0055};
        tbl[2] = '{"wr1_a5",     16, 64'h01A5,  64'h0000};
        tbl[3] = '{"wr2_3c",     16, 64'h023C,  64'h0000};
        tbl[4] = '{"rd1_a5",     16, 64'h8100,  64'h00A5};
        tbl[5] = '{"rd2_3c",     16, 64'h8200,  64'h003C};
        tbl[6] = '{"abort12",    12, 64'h04F,   64'h0000};
        tbl[7] = '{"rd4_abort",  16, 64'h8400,  64'h0000};
        tbl[8] = '{"wr5_20bit",  20, 64'h05810, 64'h0000};
        tbl[9] = '{"rd5_81",     16, 64'h8500,  64'h0081};

        spi.CS   = 1'b1;
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b0;
        model_reset();
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check("reset_miso", {63'b0, spi.MISO}, 64'h0);

        for (int i = 0; i < 10; i++) begin
            model_frame(tbl[i].n, tbl[i].tx, mrsp);
            xfer(tbl[i].n, tbl[i].tx, rx);
            check(tbl[i].name, rx, tbl[i].exp);
        end

        // Reset mid-read of reg 3 (holding 0x55) with CS kept low throughout.
        spi.CS = 1'b0;
        #200;
        shift_bits(10, 64'h8300 >> 6, rx);
        check("pre_rst_read", rx, 64'h001);
        pulse_reset();
        repeat (4) @(negedge CLK);
        check("rst_miso_cs_low", {63'b0, spi.MISO}, 64'h0);
        shift_bits(16, 64'h8300, rx);
        check("rst_held_rd", rx, 64'h0);
        shift_bits(16, 64'h03EE, rx);
        check("rst_held_wr", rx, 64'h0);
        spi.CS = 1'b1;
        #400;
        xfer(16, 64'h8300, rx);
        check("rst_no_write", rx, 64'h0);
        model_frame(16, 64'h8300, mrsp);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            w = {1'($urandom), 3'($urandom), 4'($urandom), 8'($urandom)};
            if (kind < 6) begin
                run_frame("rand16", 16, {48'b0, w});
            end else if (kind < 8) begin
                run_frame("rand20", 20, {44'b0, w, 4'($urandom)});
            end else begin
                n = $urandom_range(4, 15);
                run_frame("rand_abort", n, {48'b0, w} >> (16 - n));
            end
        end

        // Top address: frame counter when enabled, otherwise an ordinary register.
        pulse_reset();
        repeat (4) @(negedge CLK);
`ifdef SMOL_BOI_FRAME_CNT_EN
        run_frame("cnt_f1", 16, 64'h0011);
        run_frame("cnt_f2", 16, 64'h0122);
        run_frame("cnt_f3", 16, 64'h0233);
        model_frame(16, 64'h8F00, mrsp);
        xfer(16, 64'h8F00, rx);
        check("cnt_read3", rx, 64'h0003);
        run_frame("cnt_wr_ign", 16, 64'h0F77);
        model_frame(16, 64'h8F00, mrsp);
        xfer(16, 64'h8F00, rx);
        check("cnt_after_wr", rx, mrsp);
`else
        run_frame("top_wr", 16, 64'h0F77);
        model_frame(16, 64'h8F00, mrsp);
        xfer(16, 64'h8F00, rx);
        check("top_rd_77", rx, 64'h0077);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
